// File: rtl/c_req_ack_ingress_pkg.sv
// Shared definitions for the b2C ingress: payload layout, FIFO depth and FSM states.
package c_req_ack_ingress_pkg;

  typedef struct packed {
    logic [7:0]  tag;
    logic [23:0] payload;
  } b2c_payload_t;

  localparam int B2C_W        = $bits(b2c_payload_t);
  localparam int C_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_GAP
  } c_state_e;

endpackage

// File: rtl/c_req_ack_ingress_fifo.sv
// Show-ahead synchronous FIFO; count is held in its own register and is the only
// source of full/empty so pointers can wrap freely.
module c_sync_fifo
  import c_req_ack_ingress_pkg::*;
#(
  parameter int DATA_W = B2C_W,
  parameter int DEPTH  = C_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              pop_ok;

  assign pop_ok = pop && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A simultaneous push and pop leaves the count unchanged.
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/c_req_ack_ingress.sv
// b2C req/ack terminator: registered-ack FSM pushes into a show-ahead FIFO that is
// re-presented to blockC as a rdy/vld stream.
module c_req_ack_ingress
  import c_req_ack_ingress_pkg::*;
#(
  parameter int DATA_W = B2C_W,
  parameter int DEPTH  = C_FIFO_DEPTH,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [DATA_W-1:0]       req_data,
  output logic                    ack,
  output logic                    out_vld,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_rdy,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_W-1:0]        xfer_cnt
);

  localparam int                OCC_W    = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0]  FULL_CNT = OCC_W'(DEPTH);

  c_state_e         state_q, state_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Free space is judged on the current count only; a same-cycle pop does not help.
  always_comb begin
    state_d    = state_q;
    xfer_cnt_d = xfer_cnt_q;
    push       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req && (count < FULL_CNT)) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        push    = 1'b1;
        state_d = S_GAP;
        if (xfer_cnt_q != '1) begin
          xfer_cnt_d = xfer_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ack       = (state_q == S_ACK);
  assign out_vld   = (count != '0);
  assign pop       = out_vld && out_rdy;
  assign occupancy = count;
  assign xfer_cnt  = xfer_cnt_q;

  c_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (req_data),
    .pop       (pop),
    .head      (out_data),
    .count     (count)
  );

`ifndef SYNTHESIS
  // Dropping req while ack is high is a source-side protocol error; the push still happens.
  always @(posedge clk) begin
    if (rst_n && (state_q == S_ACK)) begin
      assert (req) else $error("b2C req dropped during ack cycle");
    end
  end
`endif

endmodule

// File: tb/tb_c_req_ack_ingress.sv
// Randomized and directed bench for c_req_ack_ingress against a queue-based reference model.
module tb_c_req_ack_ingress;
  import c_req_ack_ingress_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(DEPTH) + 1;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic [DATA_W-1:0] req_data = '0;
  logic              out_rdy = 1'b0;
  logic              ack;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  xfer_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered items, ack history of the current and previous cycle.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] sentData[$];
  int                ackAt[$];
  bit                mAck;
  bit                mAck1;
  int                mXfers;

  always #5 clk = ~clk;

  c_req_ack_ingress #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .occupancy (occupancy),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model on the edge.
  task automatic applyStimulus();
    int curOcc;
    bit nextAck;
    @(negedge clk);
    checkOutput("ack", ack, mAck);
    checkOutput("out_vld", out_vld, mq.size() != 0);
    if (mq.size() != 0) checkOutput("out_data", out_data, mq[0]);
    checkOutput("occupancy", occupancy, mq.size());
    checkOutput("xfer_cnt", xfer_cnt, (mXfers > SAT) ? SAT : mXfers);
    @(posedge clk);
    curOcc = mq.size();
    if (curOcc != 0 && out_rdy) void'(mq.pop_front());
    if (mAck) begin
      mq.push_back(req_data);
      mXfers++;
    end
    // Ack needs req and space last cycle, with no ack in either of the two cycles before it.
    nextAck = req && (curOcc < DEPTH) && !mAck && !mAck1;
    mAck1 = mAck;
    mAck  = nextAck;
    #1;
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    req      = 1'b0;
    out_rdy  = 1'b0;
    req_data = '0;
    #1;
    checkOutput("rst_ack", ack, 1'b0);
    checkOutput("rst_vld", out_vld, 1'b0);
    checkOutput("rst_occ", occupancy, 0);
    checkOutput("rst_cnt", xfer_cnt, 0);
    mq.delete();
    mAck   = 1'b0;
    mAck1  = 1'b0;
    mXfers = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer n items back to back, recording the cycle offset of each ack.
  task automatic sendItems(input int n);
    int sent = 0;
    int cyc  = 0;
    ackAt.delete();
    sentData.delete();
    req      = 1'b1;
    req_data = $urandom;
    while (sent < n && cyc < 20 * n + 40) begin
      applyStimulus();
      cyc++;
      if (mAck1) begin
        ackAt.push_back(cyc - 1);
        sentData.push_back(req_data);
        sent++;
        if (sent < n) req_data = $urandom;
        else req = 1'b0;
      end
    end
    req = 1'b0;
    checkOutput("send_done", sent, n);
  endtask

  initial begin
    doReset();

    // Single transfer latency.
    repeat (3) applyStimulus();
    req      = 1'b1;
    req_data = 32'hA5A5_0001;
    applyStimulus();
    checkOutput("t1_ack", ack, 1'b1);
    applyStimulus();
    req = 1'b0;
    checkOutput("t1_ack_low", ack, 1'b0);
    checkOutput("t1_vld", out_vld, 1'b1);
    checkOutput("t1_data", out_data, 32'hA5A5_0001);
    repeat (3) applyStimulus();

    // Back-to-back with the sink always ready.
    doReset();
    out_rdy = 1'b1;
    sendItems(4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_ack_cycle", (ackAt.size() > i) ? ackAt[i] : -1, 1 + 3 * i);
    end
    repeat (4) applyStimulus();
    checkOutput("t2_xfer_cnt", xfer_cnt, 4);
    checkOutput("t2_occ", occupancy, 0);

    // Full FIFO withholds ack until one slot drains.
    doReset();
    sendItems(4);
    req      = 1'b1;
    req_data = 32'h5555_0005;
    repeat (8) applyStimulus();
    checkOutput("t3_occ_full", occupancy, 4);
    checkOutput("t3_no_ack", ack, 1'b0);
    out_rdy = 1'b1;
    applyStimulus();
    out_rdy = 1'b0;
    checkOutput("t3_ack_wait", ack, 1'b0);
    applyStimulus();
    checkOutput("t3_ack", ack, 1'b1);
    applyStimulus();
    req = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("t3_occ_after", occupancy, 4);

    // Push and pop in the same cycle at occupancy 2.
    doReset();
    sendItems(2);
    req      = 1'b1;
    req_data = 32'h0BAD_F00D;
    for (int i = 0; i < 10; i++) begin
      out_rdy = mAck;
      applyStimulus();
      if (mAck1) break;
    end
    req     = 1'b0;
    out_rdy = 1'b0;
    checkOutput("t4_occ", occupancy, 2);
    checkOutput("t4_head", out_data, (sentData.size() > 1) ? sentData[1] : '0);
    repeat (2) applyStimulus();

    // Reset asserted during the ack cycle.
    doReset();
    req      = 1'b1;
    req_data = 32'h1234_5678;
    applyStimulus();
    checkOutput("t5_in_ack", ack, 1'b1);
    #2;
    doReset();
    req      = 1'b1;
    req_data = 32'h8765_4321;
    applyStimulus();
    checkOutput("t5_ack_again", ack, 1'b1);
    applyStimulus();
    req = 1'b0;
    repeat (2) applyStimulus();

    // Counter saturation.
    doReset();
    out_rdy = 1'b1;
    sendItems(17);
    repeat (4) applyStimulus();
    checkOutput("t6_sat", xfer_cnt, SAT);

    // Randomized traffic with a randomized sink.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (mAck1) begin
        if ($urandom_range(0, 1) == 1) begin
          req      = 1'b1;
          req_data = $urandom;
        end else begin
          req = 1'b0;
        end
      end else if (!req && $urandom_range(0, 2) == 0) begin
        req      = 1'b1;
        req_data = $urandom;
      end
      out_rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
